// File: rtl/wb_pkg.sv
// Shared encodings and constants for the pd3 writeback stage.
// Kind and load-size codes match the retire-bus encodings used by earlier stages.
package wb_pkg;

  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_LOAD = 2'd2;
  localparam logic [1:0] WB_LINK = 2'd3;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_e;

  localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

// File: rtl/load_extend.sv
// Combinational big-endian lane selection and sign/zero extension of load data.
// Also reports whether the size/offset pair is misaligned (reserved size behaves as word).
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_value,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    w_byte = i_rdata[31:24];
    case (i_offset)
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      2'd3:    w_byte = i_rdata[7:0];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];

  always_comb begin
    o_value = i_rdata;
    case (i_size)
      LD_BYTE: o_value = {{24{i_signed & w_byte[7]}}, w_byte};
      LD_HALF: o_value = {{16{i_signed & w_half[15]}}, w_half};
      default: o_value = i_rdata;
    endcase
  end

  assign o_misaligned = ((i_size == LD_HALF) && i_offset[0]) ||
                        ((i_size != LD_BYTE) && (i_size != LD_HALF) && (i_offset != 2'd0));

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: forms ALU / load / link results and drives the register file write port.
// Define WB_TRACE_EN to print every write and every misalign/timeout event in simulation.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind_2,
  input  logic [4:0]  in_dest_5,
  input  logic [31:0] in_alu_32,
  input  logic [31:0] in_pc_32,
  input  logic [1:0]  in_ld_size_2,
  input  logic        in_ld_signed,
  input  logic [1:0]  in_ld_offset_2,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata_32,
  output logic        w_en,
  output logic [4:0]  w_address_d_5,
  output logic [31:0] w_data_dval_32,
  output logic        err_misalign,
  output logic        err_timeout
);

  wb_state_e   r_state, w_next_state;
  logic [7:0]  r_count;
  logic [4:0]  r_dest;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_offset;
  logic        r_wen;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_err_mis;
  logic        r_err_to;

  logic        w_idle, w_accept, w_timeout, w_ld_mis;
  logic        w_do_write, w_mis_evt, w_load_start;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data, w_ext_value;
  logic [1:0]  w_ext_size, w_ext_offset;
  logic        w_ext_signed;

  assign w_idle   = (r_state == IDLE);
  assign in_ready = w_idle;
  assign w_accept = in_valid && w_idle;

  // One extender serves both the accept-time alignment check and the later data extraction.
  assign w_ext_size   = w_idle ? in_ld_size_2   : r_size;
  assign w_ext_signed = w_idle ? in_ld_signed   : r_signed;
  assign w_ext_offset = w_idle ? in_ld_offset_2 : r_offset;

  load_extend u_load_extend (
    .i_rdata      (mem_rdata_32),
    .i_size       (w_ext_size),
    .i_signed     (w_ext_signed),
    .i_offset     (w_ext_offset),
    .o_value      (w_ext_value),
    .o_misaligned (w_ld_mis)
  );

  assign w_timeout = !w_idle && !mem_rvalid && (r_count == 8'(LOAD_TIMEOUT - 1));

  always_comb begin
    w_next_state = r_state;
    w_do_write   = 1'b0;
    w_wr_addr    = r_waddr;
    w_wr_data    = r_wdata;
    w_mis_evt    = 1'b0;
    w_load_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (in_kind_2)
            WB_ALU: begin
              w_do_write = (in_dest_5 != 5'd0);
              w_wr_addr  = in_dest_5;
              w_wr_data  = in_alu_32;
            end
            WB_LINK: begin
              w_do_write = (in_dest_5 != 5'd0);
              w_wr_addr  = in_dest_5;
              w_wr_data  = in_pc_32 + LINK_OFFSET;
            end
            WB_LOAD: begin
              if (w_ld_mis) begin
                w_mis_evt = 1'b1;
              end else begin
                w_load_start = 1'b1;
                w_next_state = WAIT_LOAD;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the timeout cycle still wins.
        if (mem_rvalid) begin
          w_do_write   = (r_dest != 5'd0);
          w_wr_addr    = r_dest;
          w_wr_data    = w_ext_value;
          w_next_state = IDLE;
        end else if (w_timeout) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_count   <= 8'd0;
      r_dest    <= 5'd0;
      r_size    <= 2'd0;
      r_signed  <= 1'b0;
      r_offset  <= 2'd0;
      r_wen     <= 1'b0;
      r_waddr   <= 5'd0;
      r_wdata   <= 32'd0;
      r_err_mis <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wen   <= w_do_write;
      if (w_do_write) begin
        r_waddr <= w_wr_addr;
        r_wdata <= w_wr_data;
      end
      if (w_mis_evt) r_err_mis <= 1'b1;
      if (w_timeout) r_err_to <= 1'b1;
      if (w_load_start) begin
        r_dest   <= in_dest_5;
        r_size   <= in_ld_size_2;
        r_signed <= in_ld_signed;
        r_offset <= in_ld_offset_2;
        r_count  <= 8'd0;
      end else if (!w_idle) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign w_en           = r_wen;
  assign w_address_d_5  = r_waddr;
  assign w_data_dval_32 = r_wdata;
  assign err_misalign   = r_err_mis;
  assign err_timeout    = r_err_to;

`ifdef WB_TRACE_EN
  always @(posedge clock) begin
    if (reset_n) begin
      if (r_wen) $display("WB addr: %d data: %h", w_address_d_5, w_data_dval_32);
      if (w_timeout) $display("WB load timeout, dest %0d abandoned", r_dest);
      if (w_mis_evt) $display("WB misaligned load, dest %0d", in_dest_5);
    end
  end
`else
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized scoreboard bench for writeback_unit: a driver pushes expected writes,
// a negedge monitor pops and compares them including the cycle they should appear in.
module tb_writeback_unit;

  localparam int LT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind_2 = '0;
  logic [4:0]  in_dest_5 = '0;
  logic [31:0] in_alu_32 = '0;
  logic [31:0] in_pc_32 = '0;
  logic [1:0]  in_ld_size_2 = '0;
  logic        in_ld_signed = 1'b0;
  logic [1:0]  in_ld_offset_2 = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata_32 = '0;
  logic        w_en;
  logic [4:0]  w_address_d_5;
  logic [31:0] w_data_dval_32;
  logic        err_misalign;
  logic        err_timeout;

  always #5 clock = ~clock;

  writeback_unit #(.LOAD_TIMEOUT(LT)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_kind_2      (in_kind_2),
    .in_dest_5      (in_dest_5),
    .in_alu_32      (in_alu_32),
    .in_pc_32       (in_pc_32),
    .in_ld_size_2   (in_ld_size_2),
    .in_ld_signed   (in_ld_signed),
    .in_ld_offset_2 (in_ld_offset_2),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata_32   (mem_rdata_32),
    .w_en           (w_en),
    .w_address_d_5  (w_address_d_5),
    .w_data_dval_32 (w_data_dval_32),
    .err_misalign   (err_misalign),
    .err_timeout    (err_timeout)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t  expQ[$];
  wr_t  monE;
  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;
  logic expMis = 1'b0;
  logic expTo = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference rules: big-endian lane pick by shifting, then extend by arithmetic.
  function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input int size, input bit sgn, input int off);
    logic [31:0] v;
    int bits;
    if (size == 0) begin
      v = (rdata >> (8 * (3 - off))) & 32'hFF;
      bits = 8;
    end else if (size == 1) begin
      v = (rdata >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      bits = 16;
    end else begin
      return rdata;
    end
    if (sgn && (v >= (32'd1 << (bits - 1)))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic bit modelMisaligned(input int size, input int off);
    if (size == 1) return (off % 2) == 1;
    if (size >= 2) return off != 0;
    return 1'b0;
  endfunction

  function automatic void pushWrite(input logic [4:0] addr, input logic [31:0] data, input int when);
    wr_t w;
    w.addr = addr;
    w.data = data;
    w.cyc  = when;
    if (addr != 5'd0) expQ.push_back(w);
  endfunction

  // Monitor: every presented write must match the oldest expected one, in the expected cycle.
  always @(negedge clock) begin
    if (reset_n && w_en) begin
      tests++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: addr %0d data %h at cycle %0d, none expected",
                 w_address_d_5, w_data_dval_32, cyc);
      end else begin
        monE = expQ.pop_front();
        if (w_address_d_5 !== monE.addr || w_data_dval_32 !== monE.data || cyc != monE.cyc) begin
          failures++;
          $display("[TB] FAIL write: got addr %0d data %h cycle %0d, expected addr %0d data %h cycle %0d",
                   w_address_d_5, w_data_dval_32, cyc, monE.addr, monE.data, monE.cyc);
        end
      end
    end
  end

  // Issues one request in the current cycle; for aligned loads also plays the memory side,
  // returning data after d wait cycles (d >= LT means it arrives too late and is ignored).
  task automatic applyStimulus(input logic [1:0] kind, input logic [4:0] dest, input logic [31:0] alu,
                               input logic [31:0] pc, input logic [1:0] size, input logic sgn,
                               input logic [1:0] off, input int d, input logic [31:0] rdata);
    bit mis;
    in_valid       = 1'b1;
    in_kind_2      = kind;
    in_dest_5      = dest;
    in_alu_32      = alu;
    in_pc_32       = pc;
    in_ld_size_2   = size;
    in_ld_signed   = sgn;
    in_ld_offset_2 = off;
    checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
    mis = (kind == 2'd2) && modelMisaligned(int'(size), int'(off));
    if (kind == 2'd1) pushWrite(dest, alu, cyc + 1);
    if (kind == 2'd3) pushWrite(dest, pc + 32'd8, cyc + 1);
    if (mis) expMis = 1'b1;
    @(posedge clock); #1;
    in_valid     = 1'b0;
    in_kind_2    = 2'($urandom);
    in_dest_5    = 5'($urandom);
    in_ld_size_2 = 2'($urandom);
    if (kind == 2'd2 && !mis) begin
      checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < d; i++) begin
        mem_rdata_32 = $urandom;
        @(posedge clock); #1;
      end
      mem_rvalid   = 1'b1;
      mem_rdata_32 = rdata;
      if (d < LT) pushWrite(dest, modelLoad(rdata, int'(size), sgn, int'(off)), cyc + 1);
      else expTo = 1'b1;
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
    end
    checkOutput("err_misalign", {31'd0, err_misalign}, {31'd0, expMis});
    checkOutput("err_timeout", {31'd0, err_timeout}, {31'd0, expTo});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_w_en", {31'd0, w_en}, 32'd0);
    checkOutput("reset_addr", {27'd0, w_address_d_5}, 32'd0);
    checkOutput("reset_data", w_data_dval_32, 32'd0);
    checkOutput("reset_err_misalign", {31'd0, err_misalign}, 32'd0);
    checkOutput("reset_err_timeout", {31'd0, err_timeout}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    #9 reset_n = 1'b1;
    @(posedge clock); #1;

    $display("[TB] directed sequence");
    for (int i = 0; i < 3; i++)
      applyStimulus(2'd1, 5'd5, 32'hDEADBEEF, 32'h0, 2'd0, 1'b0, 2'd0, 0, 32'h0);
    applyStimulus(2'd3, 5'd31, 32'h0, 32'h00400020, 2'd0, 1'b0, 2'd0, 0, 32'h0);
    applyStimulus(2'd3, 5'd0, 32'h0, 32'h00400020, 2'd0, 1'b0, 2'd0, 0, 32'h0);
    applyStimulus(2'd0, 5'd7, 32'h11111111, 32'h0, 2'd0, 1'b0, 2'd0, 0, 32'h0);
    applyStimulus(2'd2, 5'd8, 32'h0, 32'h0, 2'd0, 1'b1, 2'd1, 2, 32'h1280FF34);
    applyStimulus(2'd2, 5'd8, 32'h0, 32'h0, 2'd0, 1'b0, 2'd1, 2, 32'h1280FF34);
    applyStimulus(2'd2, 5'd9, 32'h0, 32'h0, 2'd1, 1'b0, 2'd1, 0, 32'h0);
    applyStimulus(2'd2, 5'd10, 32'h0, 32'h0, 2'd1, 1'b0, 2'd2, 1, 32'hAAAA8001);
    applyStimulus(2'd2, 5'd3, 32'h0, 32'h0, 2'd2, 1'b0, 2'd0, LT - 1, 32'h13572468);
    applyStimulus(2'd2, 5'd4, 32'h0, 32'h0, 2'd2, 1'b0, 2'd0, LT + 1, 32'hCAFEF00D);
    applyStimulus(2'd1, 5'd12, 32'h0BADC0DE, 32'h0, 2'd0, 1'b0, 2'd0, 0, 32'h0);
    @(posedge clock); #1;

    $display("[TB] reset during pending load");
    in_valid = 1'b1; in_kind_2 = 2'd2; in_dest_5 = 5'd9; in_ld_size_2 = 2'd2; in_ld_offset_2 = 2'd0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b0;
    expMis = 1'b0;
    expTo = 1'b0;
    #1;
    checkOutput("midreset_w_en", {31'd0, w_en}, 32'd0);
    checkOutput("midreset_addr", {27'd0, w_address_d_5}, 32'd0);
    checkOutput("midreset_data", w_data_dval_32, 32'd0);
    checkOutput("midreset_err_misalign", {31'd0, err_misalign}, 32'd0);
    checkOutput("midreset_err_timeout", {31'd0, err_timeout}, 32'd0);
    #3 reset_n = 1'b1;
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    mem_rvalid = 1'b1; mem_rdata_32 = 32'h55667788;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_no_write", {31'd0, w_en}, 32'd0);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 60; n++) begin
      logic [4:0] dest;
      dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      applyStimulus(2'($urandom), dest, $urandom, $urandom, 2'($urandom), 1'($urandom),
                    2'($urandom), $urandom_range(0, LT + 1), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end

    repeat (3) @(posedge clock);
    #1;
    checkOutput("pending_expected_writes", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
